// File: rtl/bus_array_pkg.sv
// bus_array_pkg: shared widths, LFSR taps, FSM states and vector helpers for bus_array_driver
package bus_array_pkg;
  localparam int A_W   = 1;
  localparam int B_W   = 4;
  localparam int C_W   = 8;
  localparam int D_W   = 32;
  localparam int CNT_W = 16;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [C_W-1:0] c;
    logic [D_W-1:0] d;
  } vec_t;
  function automatic vec_t slice_vec(input logic [31:0] v);
    vec_t r;
    r.a = v[31];
    r.b = v[3:0];
    r.c = v[15:8];
    r.d = v;
    return r;
  endfunction
  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_TAPS : 32'h0);
  endfunction
  function automatic logic [31:0] fix_seed(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction
endpackage

// File: rtl/bus_array_driver_lfsr32.sv
// lfsr32: 32-bit Galois LFSR holding the vector currently on the bus; zero seed becomes 1
module lfsr32
  import bus_array_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        LOAD,
  input  logic [31:0] SEED,
  input  logic        STEP,
  output logic [31:0] Q
);
  // reload on reset or run start, otherwise advance one step per driven vector
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) Q <= fix_seed(SEED);
    else if (LOAD) Q <= fix_seed(SEED);
    else if (STEP) Q <= lfsr_next(Q);
endmodule

// File: rtl/bus_array_driver.sv
// bus_array_driver: drives LFSR vectors onto A..D and checks the sink's echo on E..H two edges later; BUS_ARRAY_DRIVER_FIRST_ERR_EN adds first-error capture
module bus_array_driver
  import bus_array_pkg::*;
#(
  parameter int          NUM_VECTORS = 16,
  parameter logic [31:0] SEED        = 32'hACE10001
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic [A_W-1:0]   A,
  output logic [B_W-1:0]   B,
  output logic [C_W-1:0]   C,
  output logic [D_W-1:0]   D,
  input  logic [A_W-1:0]   E,
  input  logic [B_W-1:0]   F,
  input  logic [C_W-1:0]   G,
  input  logic [D_W-1:0]   H,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic             ERR
`ifdef BUS_ARRAY_DRIVER_FIRST_ERR_EN
  ,
  output logic [CNT_W-1:0] FIRST_ERR_IDX,
  output logic [D_W-1:0]   FIRST_ERR_H
`endif
);
  state_t state, nxt;
  logic [31:0] q, launch_val, v0, v1;
  logic [CNT_W-1:0] idx;
  logic v0_vld, v1_vld, drn, start_run, last, step, launch, mis;
  vec_t out_v, exp_v, echo_v;
  assign start_run  = state == S_IDLE && START;
  assign last       = idx == CNT_W'(NUM_VECTORS - 1);
  assign step       = state == S_DRIVE && !last;
  assign launch     = start_run || step;
  assign launch_val = start_run ? fix_seed(SEED) : lfsr_next(q);
  assign out_v      = slice_vec(v0);
  assign exp_v      = slice_vec(v1);
  assign echo_v     = {E, F, G, H};
  assign mis        = v1_vld && echo_v != exp_v;
  assign {A, B, C, D} = out_v;
  assign BUSY = state == S_DRIVE || state == S_DRAIN;
  assign DONE = state == S_DONE;
  assign ERR  = ERR_CNT != '0;
  lfsr32 u_lfsr (
    .CLK  (CLK),
    .RST_N(RST_N),
    .LOAD (start_run),
    .SEED (SEED),
    .STEP (step),
    .Q    (q)
  );
  // state register
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= S_IDLE;
    else state <= nxt;
  // next state: DONE waits for START to drop so a held START never retriggers
  always_comb begin
    nxt = state;
    nxt = state == S_IDLE  ? (START ? S_DRIVE : S_IDLE) :
          state == S_DRIVE ? (last ? S_DRAIN : S_DRIVE) :
          state == S_DRAIN ? (drn ? S_DONE : S_DRAIN) :
                             (START ? S_DONE : S_IDLE);
  end
  // v0 is the launched vector (also the bus register), v1 the one whose echo arrives now
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      v0     <= '0;
      v0_vld <= 1'b0;
      v1     <= '0;
      v1_vld <= 1'b0;
      idx    <= '0;
      drn    <= 1'b0;
    end else begin
      v0     <= launch ? launch_val : '0;
      v0_vld <= launch;
      v1     <= v0;
      v1_vld <= v0_vld;
      idx    <= start_run ? '0 : step ? idx + 1'b1 : idx;
      drn    <= state == S_DRAIN;
    end
  // saturating per-vector mismatch count, cleared at run start
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) ERR_CNT <= '0;
    else if (start_run) ERR_CNT <= '0;
    else if (mis && ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
`ifdef BUS_ARRAY_DRIVER_FIRST_ERR_EN
  logic [CNT_W-1:0] i0, i1;
  // index travels with the vector so the first failing one can be named
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      i0 <= '0;
      i1 <= '0;
    end else begin
      i0 <= start_run ? '0 : step ? idx + 1'b1 : i0;
      i1 <= i0;
    end
  // capture only on the first mismatch of a run
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      FIRST_ERR_IDX <= '0;
      FIRST_ERR_H   <= '0;
    end else if (start_run) begin
      FIRST_ERR_IDX <= '0;
      FIRST_ERR_H   <= '0;
    end else if (mis && ERR_CNT == '0) begin
      FIRST_ERR_IDX <= i1;
      FIRST_ERR_H   <= H;
    end
`endif
endmodule

// File: tb/tb_bus_array_driver.sv
// tb_bus_array_driver: scoreboard bench for bus_array_driver with registered echo sinks; honours BUS_ARRAY_DRIVER_FIRST_ERR_EN
module tb_bus_array_driver;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int compares = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [44:0] first_abcd;

  logic start, busy, done, err, a, e;
  logic [3:0] b, f;
  logic [7:0] c, g;
  logic [31:0] d, h;
  logic [15:0] err_cnt;
  logic stuck = 1'b0, flip_en = 1'b0;
  logic [31:0] flip_val = 32'h0;

  logic start_z, busy_z, done_z, err_z, a_z, e_z;
  logic [3:0] b_z, f_z;
  logic [7:0] c_z, g_z;
  logic [31:0] d_z, h_z;
  logic [15:0] err_cnt_z;

  logic start_s, busy_s, done_s, err_s, a_s, e_s;
  logic [3:0] b_s, f_s;
  logic [7:0] c_s, g_s;
  logic [31:0] d_s, h_s;
  logic [15:0] err_cnt_s;

`ifdef BUS_ARRAY_DRIVER_FIRST_ERR_EN
  logic [15:0] fe_idx, fe_idx_z, fe_idx_s;
  logic [31:0] fe_h, fe_h_z, fe_h_s;
`endif

  bus_array_driver #(.NUM_VECTORS(16), .SEED(32'hACE10001)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .BUSY(busy), .DONE(done),
    .A(a), .B(b), .C(c), .D(d), .E(e), .F(f), .G(g), .H(h),
    .ERR_CNT(err_cnt), .ERR(err)
`ifdef BUS_ARRAY_DRIVER_FIRST_ERR_EN
    , .FIRST_ERR_IDX(fe_idx), .FIRST_ERR_H(fe_h)
`endif
  );

  bus_array_driver #(.NUM_VECTORS(1), .SEED(32'h0)) dut_z (
    .CLK(clk), .RST_N(rst_n), .START(start_z), .BUSY(busy_z), .DONE(done_z),
    .A(a_z), .B(b_z), .C(c_z), .D(d_z), .E(e_z), .F(f_z), .G(g_z), .H(h_z),
    .ERR_CNT(err_cnt_z), .ERR(err_z)
`ifdef BUS_ARRAY_DRIVER_FIRST_ERR_EN
    , .FIRST_ERR_IDX(fe_idx_z), .FIRST_ERR_H(fe_h_z)
`endif
  );

  bus_array_driver #(.NUM_VECTORS(65535), .SEED(32'h12345678)) dut_s (
    .CLK(clk), .RST_N(rst_n), .START(start_s), .BUSY(busy_s), .DONE(done_s),
    .A(a_s), .B(b_s), .C(c_s), .D(d_s), .E(e_s), .F(f_s), .G(g_s), .H(h_s),
    .ERR_CNT(err_cnt_s), .ERR(err_s)
`ifdef BUS_ARRAY_DRIVER_FIRST_ERR_EN
    , .FIRST_ERR_IDX(fe_idx_s), .FIRST_ERR_H(fe_h_s)
`endif
  );

  // one-cycle registered sinks; the main one can corrupt a chosen vector or stick G at zero
  always @(posedge clk) begin
    e <= a;
    f <= b;
    g <= stuck ? 8'h00 : c;
    h <= (flip_en && d == flip_val) ? d ^ 32'h1 : d;
    e_z <= a_z;
    f_z <= b_z;
    g_z <= c_z;
    h_z <= d_z;
    e_s <= a_s;
    f_s <= b_s;
    g_s <= c_s;
    h_s <= ~d_s;
  end

  function automatic logic [31:0] model_next(input logic [31:0] x);
    model_next = {1'b0, x[31:1]} ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  // pushes the model's vectors, starts a run on the main DUT and pops one per driven cycle;
  // returns at the falling edge after the last vector was launched
  task automatic run_vectors(input int n, input logic [31:0] seed, input bit hold);
    logic [31:0] x, v;
    x = (seed == 32'h0) ? 32'h1 : seed;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(x);
      x = model_next(x);
    end
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    first_abcd = {a, b, c, d};
    for (int k = 0; k < n; k++) begin
      v = exp_q.pop_front();
      compares++;
      if ({a, b, c, d} !== {v[31], v[3:0], v[15:8], v}) begin
        fails++;
        $display("FAIL vec%0d: got a=%b b=%h c=%h d=%h, expected a=%b b=%h c=%h d=%h",
                 k, a, b, c, d, v[31], v[3:0], v[15:8], v);
      end
      if (k < n - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    start_z = 1'b0;
    start_s = 1'b0;
    repeat (3) @(negedge clk);
    compares++;
    if ({a, b, c, d} !== 45'h0) begin
      fails++;
      $display("FAIL reset_bus: got %h expected 0", {a, b, c, d});
    end
    compares++;
    if ({busy, done, err} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: got busy/done/err=%b expected 000", {busy, done, err});
    end
    compares++;
    if (err_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset_err_cnt: got %h expected 0000", err_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ideal_echo;
    run_vectors(16, 32'hACE10001, 1'b0);
    compares++;
    if (first_abcd !== {1'b1, 4'h1, 8'h00, 32'hACE10001}) begin
      fails++;
      $display("FAIL ideal_vec0: got %h expected %h", first_abcd, {1'b1, 4'h1, 8'h00, 32'hACE10001});
    end
    @(negedge clk);
    compares++;
    if ({busy, done, a, b, c, d} !== {2'b10, 45'h0}) begin
      fails++;
      $display("FAIL ideal_drain_entry: got busy=%b done=%b d=%h expected busy=1 done=0 d=0", busy, done, d);
    end
    @(negedge clk);
    compares++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL ideal_done_early: got done=%b at t0+17 expected 0", done);
    end
    @(negedge clk);
    compares++;
    if ({busy, done} !== 2'b01) begin
      fails++;
      $display("FAIL ideal_done_t18: got busy/done=%b expected 01", {busy, done});
    end
    compares++;
    if ({err_cnt, err} !== 17'h0) begin
      fails++;
      $display("FAIL ideal_err: got err_cnt=%h err=%b expected 0/0", err_cnt, err);
    end
  endtask

  task automatic test_single_corruption;
    logic [31:0] x;
    x = 32'hACE10001;
    for (int k = 0; k < 5; k++) x = model_next(x);
    flip_val = x;
    flip_en = 1'b1;
    run_vectors(16, 32'hACE10001, 1'b0);
    repeat (3) @(negedge clk);
    flip_en = 1'b0;
    compares++;
    if ({err_cnt, err, done} !== {16'h1, 2'b11}) begin
      fails++;
      $display("FAIL single_err: got err_cnt=%h err=%b done=%b expected 0001/1/1", err_cnt, err, done);
    end
`ifdef BUS_ARRAY_DRIVER_FIRST_ERR_EN
    compares++;
    if ({fe_idx, fe_h} !== {16'd5, x ^ 32'h1}) begin
      fails++;
      $display("FAIL single_first_err: got idx=%0d h=%h expected idx=5 h=%h", fe_idx, fe_h, x ^ 32'h1);
    end
`endif
  endtask

  task automatic test_stuck_echo;
    logic [31:0] x;
    int cnt;
    x = 32'hACE10001;
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (x[15:8] != 8'h00) cnt++;
      x = model_next(x);
    end
    stuck = 1'b1;
    run_vectors(16, 32'hACE10001, 1'b1);
    repeat (3) @(negedge clk);
    compares++;
    if (err_cnt !== 16'(cnt) || err !== (cnt != 0)) begin
      fails++;
      $display("FAIL stuck_err_cnt: got %0d err=%b expected %0d", err_cnt, err, cnt);
    end
    repeat (4) @(negedge clk);
    compares++;
    if ({busy, done, d} !== {2'b01, 32'h0}) begin
      fails++;
      $display("FAIL stuck_no_retrigger: got busy=%b done=%b d=%h expected 0/1/0", busy, done, d);
    end
    compares++;
    if (err_cnt !== 16'(cnt)) begin
      fails++;
      $display("FAIL stuck_hold: got %0d expected %0d", err_cnt, cnt);
    end
    start = 1'b0;
    stuck = 1'b0;
    @(negedge clk);
    compares++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL stuck_to_idle: got busy/done=%b expected 00", {busy, done});
    end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] x;
    x = 32'hACE10001;
    for (int k = 0; k < 7; k++) x = model_next(x);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (7) @(negedge clk);
    compares++;
    if (d !== x) begin
      fails++;
      $display("FAIL midrun_vec7: got %h expected %h", d, x);
    end
    rst_n = 1'b0;
    #1;
    compares++;
    if ({a, b, c, d, busy, done, err_cnt, err} !== 64'h0) begin
      fails++;
      $display("FAIL midrun_reset: got d=%h busy=%b done=%b err_cnt=%h err=%b expected all 0",
               d, busy, done, err_cnt, err);
    end
    @(negedge clk) rst_n = 1'b1;
    run_vectors(16, 32'hACE10001, 1'b0);
    compares++;
    if (first_abcd[31:0] !== 32'hACE10001) begin
      fails++;
      $display("FAIL midrun_restart_vec0: got %h expected ace10001", first_abcd[31:0]);
    end
    repeat (3) @(negedge clk);
    compares++;
    if ({done, err_cnt} !== {1'b1, 16'h0}) begin
      fails++;
      $display("FAIL midrun_restart_err: got done=%b err_cnt=%h expected 1/0000", done, err_cnt);
    end
  endtask

  task automatic test_seed_zero_one_vector;
    @(negedge clk) start_z = 1'b1;
    @(posedge clk);
    @(negedge clk) start_z = 1'b0;
    compares++;
    if ({a_z, b_z, c_z, d_z, busy_z} !== {1'b0, 4'h1, 8'h00, 32'h1, 1'b1}) begin
      fails++;
      $display("FAIL seed0_vec0: got a=%b b=%h c=%h d=%h busy=%b expected 0/1/00/00000001/1",
               a_z, b_z, c_z, d_z, busy_z);
    end
    @(negedge clk);
    compares++;
    if ({busy_z, d_z} !== {1'b1, 32'h0}) begin
      fails++;
      $display("FAIL nv1_drain: got busy=%b d=%h expected 1/0", busy_z, d_z);
    end
    @(negedge clk);
    compares++;
    if (done_z !== 1'b0) begin
      fails++;
      $display("FAIL nv1_done_early: got %b at t0+2 expected 0", done_z);
    end
    @(negedge clk);
    compares++;
    if ({done_z, err_cnt_z} !== {1'b1, 16'h0}) begin
      fails++;
      $display("FAIL nv1_done_t3: got done=%b err_cnt=%h expected 1/0000", done_z, err_cnt_z);
    end
  endtask

  task automatic test_saturation;
    int cyc;
    @(negedge clk) start_s = 1'b1;
    @(posedge clk);
    @(negedge clk) start_s = 1'b0;
    cyc = 0;
    while (!done_s && cyc < 70000) begin
      @(negedge clk);
      cyc++;
    end
    compares++;
    if (done_s !== 1'b1) begin
      fails++;
      $display("FAIL sat_timeout: got done=%b after %0d cycles expected 1", done_s, cyc);
    end
    compares++;
    if ({err_cnt_s, err_s} !== {16'hFFFF, 1'b1}) begin
      fails++;
      $display("FAIL sat_err_cnt: got %h err=%b expected ffff/1", err_cnt_s, err_s);
    end
  endtask

  initial begin
    test_reset();
    test_ideal_echo();
    test_single_corruption();
    test_stuck_echo();
    test_reset_mid_run();
    test_seed_zero_one_vector();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
